// File: rtl/pipelined_block_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_block_subtractor
//
// Pipelined N-bit unsigned subtractor computing diff = A - B - bin. The
// operands are cut into STAGES slices of W = N/STAGES bits. Stage k subtracts
// slice k using the borrow registered by stage k-1. Finished low slices and
// still-unconsumed high operand slices travel with each transaction in skew
// registers, so every stage accepts a new transaction every cycle.
//
// Handshake: adv = !out_valid || out_ready moves the whole pipe one step.
// Bubbles are not collapsed. in_ready equals adv.
//
// Optional feature (macro SUB_OVF_FLAG_EN): adds the output ovf, which is
// the signed two's-complement overflow of A - B - bin. It is aligned with
// diff.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   A/B/bin are valid this cycle
//   in_ready   the pipe accepts input this cycle
//   A, B       N-bit unsigned minuend and subtrahend
//   bin        borrow-in
//   out_valid  diff/bout are valid
//   out_ready  the consumer accepts the output
//   diff       (A - B - bin) mod 2^N
//   bout       borrow-out, 1 iff A < B + bin
//   ovf        signed overflow (only with SUB_OVF_FLAG_EN)
//
// N must be a multiple of STAGES.
// -----------------------------------------------------------------------------
module pipelined_block_subtractor #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = N / STAGES;

  logic adv;

  // The whole pipe advances unless a valid result is waiting on the consumer.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * W;   // result bits finished before this stage
    localparam int HI = LO + W;  // result bits finished after this stage

    // Operand bits not consumed yet. The slice for this stage sits at the bottom.
    logic [N-LO-1:0] a_up;
    logic [N-LO-1:0] b_up;
    logic            bor_in;
    logic            vld_in;
    logic [W:0]      sub;
    logic [HI-1:0]   res_new;
    logic [HI-1:0]   res_d, res_q;
    logic            bor_d, bor_q;
    logic            vld_d, vld_q;

    // Bit W of the (W+1)-bit difference is the slice borrow-out.
    assign sub = {1'b0, a_up[W-1:0]} - {1'b0, b_up[W-1:0]} - {{W{1'b0}}, bor_in};

    if (k == 0) begin : g_src
      assign a_up    = A;
      assign b_up    = B;
      assign bor_in  = bin;
      assign vld_in  = in_valid && in_ready;
      assign res_new = sub[W-1:0];
    end else begin : g_src
      assign a_up    = g_stage[k-1].g_skew.a_q;
      assign b_up    = g_stage[k-1].g_skew.b_q;
      assign bor_in  = g_stage[k-1].bor_q;
      assign vld_in  = g_stage[k-1].vld_q;
      assign res_new = {sub[W-1:0], g_stage[k-1].res_q};
    end

    // Next state of the stage: load on advance, otherwise hold.
    always_comb begin
      res_d = res_q;
      bor_d = bor_q;
      vld_d = vld_q;
      if (adv) begin
        res_d = res_new;
        bor_d = sub[W];
        vld_d = vld_in;
      end else begin
        res_d = res_q;
        bor_d = bor_q;
        vld_d = vld_q;
      end
    end

    // Stage registers. Reset flushes the stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q <= '0;
        bor_q <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        res_q <= res_d;
        bor_q <= bor_d;
        vld_q <= vld_d;
      end
    end

    // The last stage has no unconsumed operand bits left to skew.
    if (k < STAGES - 1) begin : g_skew
      localparam int RW = N - HI;

      logic [RW-1:0] a_d, a_q;
      logic [RW-1:0] b_d, b_q;

      // Forward the upper operand slices on advance.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_up[N-LO-1:W];
          b_d = b_up[N-LO-1:W];
        end else begin
          a_d = a_q;
          b_d = b_q;
        end
      end

      // Skew registers for the operands.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign diff      = g_stage[STAGES-1].res_q;
  assign bout      = g_stage[STAGES-1].bor_q;
  assign out_valid = g_stage[STAGES-1].vld_q;

`ifdef SUB_OVF_FLAG_EN
  // The operand sign bits reach the last stage as the top bits of its slice.
  logic a_sign, b_sign, d_sign;
  logic ovf_d, ovf_q;

  assign a_sign = g_stage[STAGES-1].a_up[W-1];
  assign b_sign = g_stage[STAGES-1].b_up[W-1];
  assign d_sign = g_stage[STAGES-1].sub[W-1];

  // Overflow happens when the operand signs differ and the result sign differs from A.
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = (a_sign != b_sign) && (d_sign != a_sign);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register. It is aligned with the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_block_subtractor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipelined_block_subtractor (N=32, STAGES=4).
// Each accepted input pushes its expected result into a queue. Each output
// transfer pops the queue and compares the result.
// -----------------------------------------------------------------------------
module tb_pipelined_block_subtractor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB_OVF_FLAG_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        b;
    logic        o;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v;
  int   tests = 0;
  int   fails = 0;

  pipelined_block_subtractor #(.N(32), .STAGES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Full-width reference model: a 33-bit subtraction gives the borrow in bit 32.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] r;
    exp_t e;
    r   = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    e.d = r[31:0];
    e.b = r[32];
    e.o = (a[31] != b[31]) && (r[31] != a[31]);
    return e;
  endfunction

  // This task is called just after a negedge. It applies the inputs for the
  // coming posedge and queues the expected result if a transfer will occur.
  task automatic set_inputs(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic bi, input logic ordy);
    in_valid  = v;
    A         = a;
    B         = b;
    bin       = bi;
    out_ready = ordy;
    if (v && (!out_valid || ordy) && !reset) sb_q.push_back(model(a, b, bi));
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_inputs(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (out_valid !== 1'b0 || diff !== 32'd0 || bout !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b diff=%h bout=%b in_ready=%b, expected 0/0/0/1",
               out_valid, diff, bout, in_ready);
    end
`ifdef SUB_OVF_FLAG_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: ovf=%b, expected 0", ovf);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    set_inputs(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tests++;
      if (out_valid !== (j == 4)) begin
        fails++;
        $display("FAIL latency: cycle %0d out_valid=%b, expected %b", j, out_valid, (j == 4));
      end
      if (out_valid && out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL latency_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || bout !== exp_v.b) begin
            fails++;
            $display("FAIL latency_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
        end
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL latency_drain: %0d results missing, expected 0", sb_q.size());
    end
  endtask

  task automatic test_borrow();
    logic [31:0] va[8];
    logic [31:0] vb[8];
    logic        vc[8];
    va = '{32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678,
           32'h0000_0100, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000};
    vb = '{32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678,
           32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j < 8) set_inputs(1'b1, va[j], vb[j], vc[j], 1'b1);
      else if (j < 20) set_inputs(1'b1, $urandom(), $urandom(), 1'($urandom_range(1)), 1'b1);
      else set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (out_valid && out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL borrow_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || bout !== exp_v.b) begin
            fails++;
            $display("FAIL borrow_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
        end
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL borrow_drain: %0d results missing, expected 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    for (int j = 0; j < 60 && got < 20; j++) begin
      @(negedge clk);
      if (i < 20) begin
        set_inputs(1'b1, i + 100, i, 1'b0, 1'b1);
        i++;
      end else begin
        set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      end
      if (out_valid && out_ready) begin
        got++;
        if (first < 0) first = j;
        last = j;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || bout !== exp_v.b) begin
            fails++;
            $display("FAIL b2b_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
        end
      end
    end
    tests++;
    if (got != 20 || (last - first) != 19 || first != 4) begin
      fails++;
      $display("FAIL b2b_stream: got %0d outputs, first at %0d, span %0d; expected 20, 4, 19",
               got, first, last - first);
    end
  endtask

  task automatic test_backpressure();
    int          i = 0;
    int          got = 0;
    int          stalls = 0;
    logic        ordy;
    logic        prev_stall = 1'b0;
    logic [31:0] held_d = 32'd0;
    logic        held_b = 1'b0;
    for (int j = 0; j < 100 && got < 20; j++) begin
      @(negedge clk);
      ordy = !(j >= 8 && j < 13);
      if (prev_stall) begin
        tests++;
        if (diff !== held_d || bout !== held_b) begin
          fails++;
          $display("FAIL bp_hold: diff=%h bout=%b, expected held diff=%h bout=%b",
                   diff, bout, held_d, held_b);
        end
      end
      set_inputs(i < 20, i + 100, i, 1'b0, ordy);
      tests++;
      if (in_ready !== (!out_valid || ordy)) begin
        fails++;
        $display("FAIL bp_in_ready: in_ready=%b, expected %b", in_ready, (!out_valid || ordy));
      end
      if (i < 20 && in_ready) i++;
      prev_stall = out_valid && !ordy;
      if (prev_stall) stalls++;
      held_d = diff;
      held_b = bout;
      if (out_valid && out_ready) begin
        got++;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL bp_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || bout !== exp_v.b) begin
            fails++;
            $display("FAIL bp_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
        end
      end
    end
    tests++;
    if (got != 20 || sb_q.size() != 0 || stalls != 5) begin
      fails++;
      $display("FAIL bp_count: got %0d, left %0d, stalls %0d; expected 20, 0, 5",
               got, sb_q.size(), stalls);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_inputs(1'b1, 32'd11, 32'd1, 1'b0, 1'b1);
    @(negedge clk);
    set_inputs(1'b1, 32'd22, 32'd2, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    set_inputs(1'b1, 32'd33, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush: cycle %0d out_valid=%b diff=%h, expected out_valid 0", j, out_valid, diff);
      end
      if (j == 5) set_inputs(1'b1, 32'd7, 32'd2, 1'b0, 1'b1);
      else set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    end
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tests++;
      if (out_valid !== (j == 4)) begin
        fails++;
        $display("FAIL post_reset_latency: cycle %0d out_valid=%b, expected %b", j, out_valid, (j == 4));
      end
      if (out_valid && out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL post_reset_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || diff !== 32'd5 || bout !== exp_v.b) begin
            fails++;
            $display("FAIL post_reset_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
        end
      end
    end
  endtask

  task automatic test_ovf();
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic        vc[5];
    va = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003, 32'h8000_0000, 32'h4000_0000};
    vb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hC000_0000};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j < 5) set_inputs(1'b1, va[j], vb[j], vc[j], 1'b1);
      else set_inputs(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (out_valid && out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL ovf_extra: diff=%h with nothing expected", diff);
        end else begin
          exp_v = sb_q.pop_front();
          if (diff !== exp_v.d || bout !== exp_v.b) begin
            fails++;
            $display("FAIL ovf_data: diff=%h bout=%b, expected diff=%h bout=%b",
                     diff, bout, exp_v.d, exp_v.b);
          end
`ifdef SUB_OVF_FLAG_EN
          tests++;
          if (ovf !== exp_v.o) begin
            fails++;
            $display("FAIL ovf_flag: ovf=%b for diff=%h, expected %b", ovf, diff, exp_v.o);
          end
`endif
        end
      end
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL ovf_drain: %0d results missing, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_borrow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_ovf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_block_subtractor.md
Name: pipelined_block_subtractor

Overview:
- Pipelined N-bit unsigned subtractor; the inverse arithmetic path to carry_save_adder_pipeline in the datapath.
- Computes diff = A - B - bin as STAGES chained blocks, each N/STAGES bits wide. Each block takes its borrow from the previous pipeline stage.
- Valid/ready handshake on input and output; stalls the whole pipe under output backpressure.

Parameters:
- N, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = number of borrow blocks; slice width W = N/STAGES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  A/B/bin valid this cycle
- in_ready  output  1  pipe accepts input this cycle
- A  input  N  minuend, unsigned
- B  input  N  subtrahend, unsigned
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts output
- diff  output  N  (A - B - bin) mod 2^N
- bout  output  1  borrow-out; 1 iff A < B + bin as unsigned (N+1)-bit compare
- ovf  output  1  present only with SUB_OVF_FLAG_EN

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk.
  - Clears every stage valid bit, all skew/result registers, and the borrow chain.
  - After reset: out_valid=0, diff=0, bout=0, ovf=0, in_ready=1.
- Reset mid-operation: all in-flight transactions are discarded with no output. Reset has priority over any concurrent handshake.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid/out_ready only, not from in_valid.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage structure (k = 0..STAGES-1). When adv=1, stage k:
  - computes slice k: {b_k, d_k} = A_k - B_k - b_(k-1), where b_(-1) = bin;
  - registers d_k and b_k;
  - carries the finished lower slices and the still-unprocessed upper A/B slices forward in skew registers;
  - sets its valid bit to the previous stage's valid (stage 0 takes in_valid && in_ready).
- Stall: when adv=0, all stage registers and valid bits hold. Outputs are stable while out_valid && !out_ready.
- Bubbles: not collapsed. Invalid stages advance with adv like valid ones. Register contents of invalid stages are don't-care, but diff/bout only change on an adv cycle.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall; each stall cycle adds one. Throughput is 1 per cycle while out_ready=1.
- Ordering: strict FIFO; no drops, no duplicates.
- Output: diff = concatenation of all d_k; bout = b_(STAGES-1) of the final stage.
- Wrap-around: modulo 2^N. Example: 0 - 1 - 0 gives diff=0xFFFFFFFF, bout=1.
- Boundary cases:
  - A=B, bin=0 gives diff=0, bout=0.
  - A=B, bin=1 gives diff=all ones, bout=1.
  - Borrow must ripple through every slice: 0x00000000 - 0x00000001.

Optional Feature:
- Macro: SUB_OVF_FLAG_EN.
- Defined: adds output ovf, the signed two's-complement overflow of A - B - bin.
  - ovf = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]).
  - A[N-1] and B[N-1] are pipelined alongside the data. ovf is aligned with diff, reset to 0, and holds under stall.
- Undefined: port ovf and its sign pipeline registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then drive in_valid=1 with A=0x00000010, B=0x00000001, bin=0, out_ready=1 -> out_valid rises exactly 4 cycles after the transfer with diff=0x0000000F, bout=0; after reset, out_valid=0, diff=0, in_ready=1.
2. Borrow chain across all slices: A=0x00000000, B=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1. Then A=0x00000005, B=0x00000005, bin=1 -> diff=0xFFFFFFFF, bout=1.
3. Back-to-back stream: A=i+100, B=i for i=0..19, bin=0, out_ready=1 -> 20 consecutive outputs, all diff=100, bout=0, in order, no gaps after the 4-cycle fill.
4. Backpressure: stream as in scenario 3, hold out_ready=0 for 5 cycles mid-stream.
   - in_ready=0 whenever out_valid && !out_ready.
   - diff/bout stable while stalled.
   - No transaction lost or duplicated; the count of 20 is preserved.
5. Reset mid-operation: load 3 transactions, assert reset for 1 cycle at cycle 2 -> out_valid stays 0 with no output from the flushed transactions. The next input A=7, B=2 yields diff=5 after 4 cycles.
6. With SUB_OVF_FLAG_EN:
   - A=0x80000000, B=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1.
   - A=0x7FFFFFFF, B=0xFFFFFFFF, bin=0 -> diff=0x80000000, bout=1, ovf=1.
   - A=3, B=1 -> ovf=0.
